// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
package timer_pkg;

  // Default width of the period and remaining-tick count.
  localparam int CNT_W_DEFAULT = 16;

  // Timer control state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : timer_pkg

// File: rtl/load_down_counter.sv
// Loadable down-counter. A load takes priority over a decrement. The count
// saturates at zero. zero_next_o flags that the next decrement reaches zero.
module load_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_next_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load wins, otherwise decrement. The count never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign zero_next_o = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule : load_down_counter

// File: rtl/interval_timer.sv
// Programmable interval timer. It counts time-base ticks down from a loaded
// period. On expiry it pulses expire_o and sets a sticky irq. In periodic mode
// it reloads the period; in one-shot mode it stops. ovr_o records an expiry
// that occurs while irq_o is still pending.
module interval_timer
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             oneshot_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             irq_clr_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             expire_o,
  output logic             irq_o,
  output logic             ovr_o
);

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic             oneshot_q, oneshot_d;
  logic             irq_q,     irq_d;
  logic             ovr_q,     ovr_d;
  logic             expire_q,  expire_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_at_one;
  logic             start_ok;

  // A start command with a zero period has no effect at all.
  assign start_ok = start_i && (period_i != '0);

  load_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cnt_load),
    .load_val_i  (cnt_load_val),
    .en_i        (cnt_dec),
    .count_o     (remaining_o),
    .zero_next_o (cnt_at_one)
  );

  // FSM next state, counter control and sticky flag updates.
  // Priority order is stop, then start, then tick.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    oneshot_d    = oneshot_q;
    cnt_load     = 1'b0;
    cnt_load_val = period_i;
    cnt_dec      = 1'b0;
    expire_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!stop_i && start_ok) begin
          period_d  = period_i;
          oneshot_d = oneshot_i;
          cnt_load  = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (start_ok) begin
          period_d  = period_i;
          oneshot_d = oneshot_i;
          cnt_load  = 1'b1;
        end else if (tick_i) begin
          if (cnt_at_one) begin
            expire_d = 1'b1;
            cnt_load = 1'b1;
            if (oneshot_q) begin
              cnt_load_val = '0;
              state_d      = IDLE;
            end else begin
              cnt_load_val = period_q;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An expiry wins over a clear in the same cycle.
    irq_d = expire_d | (irq_q & ~irq_clr_i);
    ovr_d = (expire_d & irq_q) | (ovr_q & ~irq_clr_i);
  end

  // State and flag registers. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      expire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      expire_q  <= expire_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign expire_o = expire_q;
  assign irq_o    = irq_q;
  assign ovr_o    = ovr_q;

endmodule : interval_timer

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random
// traffic, compared every cycle against a behavioural model.
module tb_interval_timer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick_i, start_i, stop_i, oneshot_i, irq_clr_i;
  logic [W-1:0] period_i;
  logic         busy_o, expire_o, irq_o, ovr_o;
  logic [W-1:0] remaining_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state, kept as plain integers.
  int m_busy, m_rem, m_per, m_one, m_irq, m_ovr, m_exp;

  interval_timer #(.CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .oneshot_i   (oneshot_i),
    .period_i    (period_i),
    .irq_clr_i   (irq_clr_i),
    .busy_o      (busy_o),
    .remaining_o (remaining_o),
    .expire_o    (expire_o),
    .irq_o       (irq_o),
    .ovr_o       (ovr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    check("busy",      int'(busy_o),      m_busy);
    check("remaining", int'(remaining_o), m_rem);
    check("expire",    int'(expire_o),    m_exp);
    check("irq",       int'(irq_o),       m_irq);
    check("ovr",       int'(ovr_o),       m_ovr);
  endtask

  // One clock with the given inputs. The model advances from the spec rules,
  // then the DUT is compared just after the edge.
  task automatic step(input bit t, input bit s, input bit p, input bit o,
                      input int per, input bit c, input bit r = 1'b0);
    int exp_now;
    tick_i = t; start_i = s; stop_i = p; oneshot_i = o;
    period_i = per[W-1:0]; irq_clr_i = c; rst = r;
    @(posedge clk);
    exp_now = 0;
    if (r) begin
      m_busy = 0; m_rem = 0; m_per = 0; m_one = 0; m_irq = 0; m_ovr = 0;
    end else begin
      if (m_busy == 1) begin
        if (p) m_busy = 0;
        else if (s && per != 0) begin m_rem = per; m_per = per; m_one = o; end
        else if (t) begin
          if (m_rem == 1) begin
            exp_now = 1;
            if (m_one == 1) begin m_rem = 0; m_busy = 0; end
            else m_rem = m_per;
          end else m_rem = m_rem - 1;
        end
      end else if (!p && s && per != 0) begin
        m_busy = 1; m_rem = per; m_per = per; m_one = o;
      end
      m_ovr = (exp_now == 1 && m_irq == 1) ? 1 : ((c) ? 0 : m_ovr);
      m_irq = (exp_now == 1) ? 1 : ((c) ? 0 : m_irq);
    end
    m_exp = exp_now;
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tick_i = 0; start_i = 0; stop_i = 0; oneshot_i = 0; period_i = '0; irq_clr_i = 0;
    rst = 1'b1;
    m_busy = 0; m_rem = 0; m_per = 0; m_one = 0; m_irq = 0; m_ovr = 0; m_exp = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset_busy_lit", int'(busy_o), 0);
    $display("reset: busy=%0d rem=%0d irq=%0d", busy_o, remaining_o, irq_o);

    // Periodic, period 3, tick every 4 cycles.
    step(0, 1, 0, 0, 3, 0);
    check("periodic_load_lit", int'(remaining_o), 3);
    for (int k = 0; k < 6; k++) begin
      idle_cycles(3);
      step(1, 0, 0, 0, 0, 0);
      $display("periodic tick %0d: rem=%0d exp=%0d irq=%0d", k, remaining_o, expire_o, irq_o);
    end
    step(0, 0, 1, 0, 0, 1);

    // One-shot period 2, then extra ticks change nothing.
    step(0, 1, 0, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("oneshot_exp_lit", int'(expire_o), 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    $display("oneshot: busy=%0d rem=%0d irq=%0d", busy_o, remaining_o, irq_o);
    step(0, 0, 0, 0, 0, 1);

    // Overrun: period 1, two consecutive ticks, then clear.
    step(0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("ovr_set_lit", int'(ovr_o), 1);
    step(0, 0, 0, 0, 0, 1);
    check("ovr_clr_lit", int'(ovr_o), 0);
    $display("overrun: irq=%0d ovr=%0d", irq_o, ovr_o);

    // Collisions: start+stop in RUN, start+tick, clear+expiry.
    step(0, 1, 1, 0, 7, 0);
    step(0, 1, 0, 0, 4, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    check("clr_vs_expiry_lit", int'(irq_o), 1);
    $display("collisions: busy=%0d rem=%0d irq=%0d", busy_o, remaining_o, irq_o);
    step(0, 0, 1, 0, 0, 1);

    // Period zero is ignored in IDLE and in RUN.
    step(0, 1, 0, 0, 0, 0);
    check("period0_idle_lit", int'(busy_o), 0);
    step(0, 1, 0, 0, 5, 0);
    step(1, 1, 0, 0, 0, 0);
    $display("period0: busy=%0d rem=%0d", busy_o, remaining_o);

    // Reset mid-count at remaining 5.
    step(0, 1, 0, 0, 8, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0);
    check("rem5_lit", int'(remaining_o), 5);
    step(1, 0, 0, 0, 0, 0, 1);
    $display("reset mid-count: busy=%0d rem=%0d exp=%0d", busy_o, remaining_o, expire_o);

    // Max period one-shot: expiry after 65535 ticks.
    step(0, 1, 0, 1, 65535, 0);
    for (int k = 0; k < 65534; k++) step(1, 0, 0, 0, 0, 0);
    check("max_before_exp_lit", int'(expire_o), 0);
    step(1, 0, 0, 0, 0, 0);
    check("max_exp_lit", int'(expire_o), 1);
    $display("max period: exp=%0d busy=%0d rem=%0d", expire_o, busy_o, remaining_o);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit t, s, p, o, c, r;
      int per;
      t   = ($urandom_range(0, 99) < 50);
      s   = ($urandom_range(0, 99) < 6);
      p   = ($urandom_range(0, 99) < 3);
      o   = ($urandom_range(0, 1) == 1);
      c   = ($urandom_range(0, 99) < 10);
      r   = ($urandom_range(0, 999) < 5);
      per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
      step(t, s, p, o, per, c, r);
      if (k % 500 == 0)
        $display("random %0d: busy=%0d rem=%0d irq=%0d ovr=%0d", k, busy_o, remaining_o, irq_o, ovr_o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_interval_timer
